rx_packet_controller: RTL and testbench
=======================================

RX_PACKET_CONTROLLER -- requirements
Module: rx_packet_controller

Interface
REQ-001 Parameter MAX_BYTES, default 66, max bytes after PID (64 data + 2 CRC16).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, WAIT_PKT cycles before timeout.
REQ-003 clock  input  1  single clock; all state changes on posedge clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 rec_start  input  1  one-cycle pulse arming reception.
REQ-006 in_bit  input  1  decoded bit from unstuff/CRC16 stage, LSB first, SYNC already stripped.
REQ-007 bit_valid  input  1  in_bit qualifier (upstream sending).
REQ-008 eop  input  1  one-cycle pulse, SE0 end-of-packet detected.
REQ-009 crc_valid  input  1  CRC16 residue-good flag, valid in the cycle eop is high.
REQ-010 pid  output  4  received PID[3:0], held until next rec_start.
REQ-011 data_byte  output  8  assembled byte, held until next byte.
REQ-012 byte_valid  output  1  one-cycle pulse per assembled post-PID byte.
REQ-013 byte_count  output  7  post-PID bytes accepted this packet.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 pkt_done  output  1  one-cycle pulse, packet finished (good or bad).
REQ-016 err_code  output  3  0 none, 1 PID check, 2 misaligned, 3 overflow, 4 CRC, 5 timeout; valid with pkt_done, held until next rec_start.

Function
REQ-017 States: IDLE, WAIT_PKT, GET_PID, GET_DATA, FINISH; FINISH lasts exactly one cycle.
REQ-018 IDLE: rec_start -> WAIT_PKT; clear pid, byte_count, err_code, bit counter.
REQ-019 WAIT_PKT: first bit_valid -> GET_PID, bit captured as bit 0.
REQ-020 Bits shifted right into 8-bit register (new bit enters MSB); byte complete after 8 accepted bits.
REQ-021 GET_PID: 8th bit -> check PID[7:4] == ~PID[3:0]; pass -> pid updated, GET_DATA; fail -> err 1, FINISH.
REQ-022 GET_DATA: each 8th bit -> data_byte updated, byte_valid pulse next cycle, byte_count +1.
REQ-023 Byte with byte_count already == MAX_BYTES -> err 3, FINISH; byte not emitted.
REQ-024 eop in GET_PID, or in GET_DATA with partial byte (bit counter != 0) -> err 2, FINISH.
REQ-025 eop in GET_DATA aligned: PID DATA0 (0011) / DATA1 (1011) with crc_valid=0 -> err 4; else err 0; -> FINISH.
REQ-026 Handshake/token packets (no data bytes) complete with err 0 on aligned eop; crc_valid ignored.
REQ-027 bit_valid and eop same cycle: bit accepted first, then eop evaluated including that bit.
REQ-028 FINISH: pkt_done=1 one cycle, -> IDLE; pkt_done latency = 1 cycle after eop/error cycle.
REQ-029 rec_start while busy ignored; eop in IDLE/WAIT_PKT ignored; bit_valid in IDLE ignored.
REQ-030 byte_count saturates at MAX_BYTES, never wraps.

Reset
REQ-031 reset_n low: state IDLE, all outputs 0, counters and shift register 0, immediately (async).
REQ-032 Reset mid-packet discards partial data; no pkt_done generated.
REQ-033 Reset deassertion synchronous to clock via the system reset path; first active edge after release sees IDLE.

Configuration
REQ-034 Macro RX_PACKET_CONTROLLER_TIMEOUT_EN: defined -> WAIT_PKT counts cycles from entry, reaching TIMEOUT_CYCLES without bit_valid -> err 5, FINISH.
REQ-035 Undefined -> no timeout counter synthesized, WAIT_PKT waits indefinitely, err 5 never produced.
REQ-036 bit_valid in the same cycle the count reaches TIMEOUT_CYCLES -> bit accepted, no timeout.

Verification
REQ-037 rec_start, DATA0 PID 0xC3, 8 data bytes 0x00..0x07, 2 CRC bytes, eop with crc_valid=1 -> 10 byte_valid pulses, byte_count=10, pid=0011, pkt_done, err 0.
REQ-038 Same packet, crc_valid=0 at eop -> pkt_done, err 4, byte_count=10.
REQ-039 PID byte 0x33 -> pkt_done after 8th bit, err 1, no byte_valid.
REQ-040 ACK 0xD2 then 3 extra bits then eop -> err 2; ACK 0xD2 then eop -> err 0, byte_count=0.
REQ-041 67 post-PID bytes without eop -> 66 byte_valid, err 3, byte_count=66.
REQ-042 With RX_PACKET_CONTROLLER_TIMEOUT_EN: rec_start, no bits for 255 cycles -> pkt_done, err 5; without macro, busy stays 1; reset_n pulse mid-packet -> busy=0, no pkt_done.

Source files
------------

// File: rtl/rx_packet_controller_if.sv
// Bit-stream and status bundle between the unstuff/CRC stage, rx_packet_controller and its consumer.
// The slave modport is the controller's view and the master modport is the driver/consumer's view.
interface rx_packet_controller_if;
  logic       rec_start;
  logic       in_bit;
  logic       bit_valid;
  logic       eop;
  logic       crc_valid;
  logic [3:0] pid;
  logic [7:0] data_byte;
  logic       byte_valid;
  logic [6:0] byte_count;
  logic       busy;
  logic       pkt_done;
  logic [2:0] err_code;

  modport master (
    output rec_start, in_bit, bit_valid, eop, crc_valid,
    input  pid, data_byte, byte_valid, byte_count, busy, pkt_done, err_code
  );

  modport slave (
    input  rec_start, in_bit, bit_valid, eop, crc_valid,
    output pid, data_byte, byte_valid, byte_count, busy, pkt_done, err_code
  );
endinterface

// File: rtl/rx_packet_controller.sv
// USB-style receive packet controller: PID check, byte assembly, end-of-packet classification.
// Defining RX_PACKET_CONTROLLER_TIMEOUT_EN adds a WAIT_PKT timeout after TIMEOUT_CYCLES idle cycles.
module rx_packet_controller #(
  parameter int MAX_BYTES      = 66,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                   clock,
  input logic                   reset_n,
  rx_packet_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_PKT = 3'd1,
    GET_PID  = 3'd2,
    GET_DATA = 3'd3,
    FINISH   = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_PID   = 3'd1;
  localparam logic [2:0] ERR_ALIGN = 3'd2;
  localparam logic [2:0] ERR_OVF   = 3'd3;
  localparam logic [2:0] ERR_CRC   = 3'd4;
  localparam logic [2:0] ERR_TMO   = 3'd5;
  localparam logic [6:0] MAX_CNT   = 7'(MAX_BYTES);

  // The upper nibble of a PID byte must be the complement of the lower nibble.
  function automatic logic pid_ok_f(input logic [7:0] pid_byte);
    return (pid_byte[7:4] == ~pid_byte[3:0]);
  endfunction

  // Only DATA0/DATA1 carry a CRC16 worth judging at an aligned end of packet.
  function automatic logic [2:0] eop_err_f(input logic [3:0] pid_val, input logic crc_ok);
    if (((pid_val == 4'b0011) || (pid_val == 4'b1011)) && !crc_ok) begin
      return ERR_CRC;
    end else begin
      return ERR_NONE;
    end
  endfunction

  state_t     state_r;
  logic [6:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic [3:0] pid_r;
  logic [7:0] data_byte_r;
  logic       byte_valid_r;
  logic [6:0] byte_count_r;
  logic       busy_r;
  logic       pkt_done_r;
  logic [2:0] err_code_r;
  logic [7:0] byte_s;
  logic       byte_done_s;
  logic       tmo_hit_s;

  // Bits arrive LSB first; the seven bits held so far plus the incoming one form the byte.
  assign byte_s      = {bus.in_bit, shift_r};
  assign byte_done_s = bus.bit_valid && (bit_cnt_r == 3'd7);

`ifdef RX_PACKET_CONTROLLER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt_r;

  assign tmo_hit_s = (tmo_cnt_r == TW'(TIMEOUT_CYCLES - 1));

  // Counts cycles spent in WAIT_PKT since entry; cleared in every other state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_r <= TW'(0);
    end else if ((state_r == WAIT_PKT) && !tmo_hit_s) begin
      tmo_cnt_r <= tmo_cnt_r + TW'(1);
    end else begin
      tmo_cnt_r <= TW'(0);
    end
  end
`else
  // WAIT_PKT never times out in this build.
  assign tmo_hit_s = (TIMEOUT_CYCLES < 0);
`endif

  // Receive FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      shift_r      <= 7'd0;
      bit_cnt_r    <= 3'd0;
      pid_r        <= 4'd0;
      data_byte_r  <= 8'd0;
      byte_valid_r <= 1'b0;
      byte_count_r <= 7'd0;
      busy_r       <= 1'b0;
      pkt_done_r   <= 1'b0;
      err_code_r   <= ERR_NONE;
    end else begin
      byte_valid_r <= 1'b0;
      pkt_done_r   <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.rec_start) begin
            state_r      <= WAIT_PKT;
            busy_r       <= 1'b1;
            shift_r      <= 7'd0;
            bit_cnt_r    <= 3'd0;
            pid_r        <= 4'd0;
            byte_count_r <= 7'd0;
            err_code_r   <= ERR_NONE;
          end else begin
            busy_r <= 1'b0;
          end
        end
        WAIT_PKT: begin
          if (bus.bit_valid) begin
            shift_r   <= byte_s[7:1];
            bit_cnt_r <= 3'd1;
            if (bus.eop) begin
              state_r    <= FINISH;
              pkt_done_r <= 1'b1;
              err_code_r <= ERR_ALIGN;
            end else begin
              state_r <= GET_PID;
            end
          end else if (tmo_hit_s) begin
            state_r    <= FINISH;
            pkt_done_r <= 1'b1;
            err_code_r <= ERR_TMO;
          end else begin
            state_r <= WAIT_PKT;
          end
        end
        GET_PID: begin
          if (bus.bit_valid) begin
            shift_r   <= byte_s[7:1];
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          if (byte_done_s) begin
            if (!pid_ok_f(byte_s)) begin
              state_r    <= FINISH;
              pkt_done_r <= 1'b1;
              err_code_r <= ERR_PID;
            end else if (bus.eop) begin
              // PID completes together with eop: judge it against the PID just received.
              pid_r      <= byte_s[3:0];
              state_r    <= FINISH;
              pkt_done_r <= 1'b1;
              err_code_r <= eop_err_f(byte_s[3:0], bus.crc_valid);
            end else begin
              pid_r   <= byte_s[3:0];
              state_r <= GET_DATA;
            end
          end else if (bus.eop) begin
            state_r    <= FINISH;
            pkt_done_r <= 1'b1;
            err_code_r <= ERR_ALIGN;
          end else begin
            state_r <= GET_PID;
          end
        end
        GET_DATA: begin
          if (bus.bit_valid) begin
            shift_r   <= byte_s[7:1];
            bit_cnt_r <= bit_cnt_r + 3'd1;
          end
          if (byte_done_s) begin
            if (byte_count_r == MAX_CNT) begin
              state_r    <= FINISH;
              pkt_done_r <= 1'b1;
              err_code_r <= ERR_OVF;
            end else begin
              data_byte_r  <= byte_s;
              byte_valid_r <= 1'b1;
              byte_count_r <= byte_count_r + 7'd1;
              if (bus.eop) begin
                state_r    <= FINISH;
                pkt_done_r <= 1'b1;
                err_code_r <= eop_err_f(pid_r, bus.crc_valid);
              end else begin
                state_r <= GET_DATA;
              end
            end
          end else if (bus.eop) begin
            state_r    <= FINISH;
            pkt_done_r <= 1'b1;
            if ((bit_cnt_r != 3'd0) || bus.bit_valid) begin
              err_code_r <= ERR_ALIGN;
            end else begin
              err_code_r <= eop_err_f(pid_r, bus.crc_valid);
            end
          end else begin
            state_r <= GET_DATA;
          end
        end
        FINISH: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pid        = pid_r;
  assign bus.data_byte  = data_byte_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.byte_count = byte_count_r;
  assign bus.busy       = busy_r;
  assign bus.pkt_done   = pkt_done_r;
  assign bus.err_code   = err_code_r;

endmodule

// File: tb/tb_rx_packet_controller.sv
// Randomized bench for rx_packet_controller: packets are described as byte lists and the
// expected outcome is derived from the packet rules; a monitor collects emitted bytes and pkt_done.
module tb_rx_packet_controller;
  localparam int MAX_B = 66;
  localparam int TMO   = 255;

  typedef logic [7:0] byteq_t[$];

  logic clock;
  logic reset_n;
  int   total;
  int   bad;
  int   cyc;

  logic [7:0] rx_q[$];
  int         done_n;
  int         done_cyc;
  logic [2:0] done_err;
  logic [6:0] done_bc;
  logic [3:0] done_pid;

  rx_packet_controller_if bus();

  rx_packet_controller #(.MAX_BYTES(MAX_B), .TIMEOUT_CYCLES(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Output monitor, sampled on the inactive edge.
  always @(negedge clock) begin
    if (bus.byte_valid) rx_q.push_back(bus.data_byte);
    if (bus.pkt_done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
      done_err = bus.err_code;
      done_bc  = bus.byte_count;
      done_pid = bus.pid;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_value(input string tag, input int got, input int exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic bv, input logic b, input logic e, input logic c);
    bus.rec_start = rs;
    bus.bit_valid = bv;
    bus.in_bit    = b;
    bus.eop       = e;
    bus.crc_valid = c;
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.rec_start = 1'b0;
    bus.bit_valid = 1'b0;
    bus.in_bit    = 1'b0;
    bus.eop       = 1'b0;
    bus.crc_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    @(negedge clock);
    for (int w = 0; w < 50 && bus.busy; w++) @(negedge clock);
    check_value({tag, " idle_wait"}, bus.busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_value({tag, " busy"}, bus.busy, 0);
    check_value({tag, " pkt_done"}, bus.pkt_done, 0);
    check_value({tag, " byte_valid"}, bus.byte_valid, 0);
    check_value({tag, " pid"}, bus.pid, 0);
    check_value({tag, " byte_count"}, bus.byte_count, 0);
    check_value({tag, " err_code"}, bus.err_code, 0);
    check_value({tag, " data_byte"}, bus.data_byte, 0);
  endtask

  // Asynchronous reset pulse in the middle of the low clock phase.
  task automatic reset_pulse(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero_outputs(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic run_pkt(input string name, input logic [7:0] pid_byte, input byteq_t body,
                         input int extra_bits, input logic crc_bit, input int pre_gap, input bit rnd);
    logic       bits[$];
    int         bit_cyc[$];
    int         exp_err;
    int         exp_n;
    int         exp_bitidx;
    int         exp_done_cyc;
    int         eop_cyc;
    logic [3:0] exp_pid;
    bit         eop_with_last;
    bit         busy_now;
    for (int i = 0; i < 8; i++) bits.push_back(pid_byte[i]);
    foreach (body[k]) for (int i = 0; i < 8; i++) bits.push_back(body[k][i]);
    for (int i = 0; i < extra_bits; i++) bits.push_back(1'($urandom_range(0, 1)));

    // Expected outcome from the packet rules.
    exp_pid    = 4'd0;
    exp_n      = 0;
    exp_bitidx = -1;
    if (pid_byte[7:4] != ~pid_byte[3:0]) begin
      exp_err    = 1;
      exp_bitidx = 7;
    end else begin
      exp_pid = pid_byte[3:0];
      if (body.size() > MAX_B) begin
        exp_err    = 3;
        exp_n      = MAX_B;
        exp_bitidx = 8 * (MAX_B + 2) - 1;
      end else begin
        exp_n = body.size();
        if (extra_bits != 0) exp_err = 2;
        else if (((pid_byte[3:0] == 4'b0011) || (pid_byte[3:0] == 4'b1011)) && !crc_bit) exp_err = 4;
        else exp_err = 0;
      end
    end

    wait_idle(name);
    rx_q.delete();
    done_n = 0;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) drive(1'b0, 1'b1, 1'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int g = 0; g < pre_gap; g++) begin
      drive(1'b0, 1'b0, 1'($urandom), rnd && ($urandom_range(0, 5) == 0), 1'($urandom));
    end
    eop_with_last = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
    eop_cyc = 0;
    for (int i = 0; i < bits.size(); i++) begin
      busy_now = (exp_bitidx < 0) || (i <= exp_bitidx);
      if (rnd) begin
        repeat ($urandom_range(0, 2))
          drive(busy_now && ($urandom_range(0, 15) == 0), 1'b0, 1'($urandom), 1'b0, 1'($urandom));
      end
      bit_cyc.push_back(cyc);
      if ((i == bits.size() - 1) && eop_with_last) begin
        eop_cyc = cyc;
        drive(1'b0, 1'b1, bits[i], 1'b1, crc_bit);
      end else begin
        drive(rnd && busy_now && ($urandom_range(0, 15) == 0), 1'b1, bits[i], 1'b0,
              rnd ? 1'($urandom) : 1'b0);
      end
    end
    if (!eop_with_last) begin
      if (rnd) repeat ($urandom_range(0, 2)) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
      eop_cyc = cyc;
      drive(1'b0, 1'b0, 1'b0, 1'b1, crc_bit);
    end
    clear_inputs();
    for (int w = 0; w < 40 && done_n == 0; w++) @(negedge clock);
    repeat (3) @(negedge clock);

    exp_done_cyc = (exp_bitidx >= 0) ? bit_cyc[exp_bitidx] + 1 : eop_cyc + 1;
    check_value({name, " done_cnt"}, done_n, 1);
    check_value({name, " err"}, done_err, exp_err);
    check_value({name, " byte_count"}, done_bc, exp_n);
    check_value({name, " pid"}, done_pid, exp_pid);
    check_value({name, " done_latency"}, done_cyc, exp_done_cyc);
    check_value({name, " nbytes"}, rx_q.size(), exp_n);
    for (int k = 0; k < exp_n && k < rx_q.size(); k++) begin
      check_value($sformatf("%s byte%0d", name, k), rx_q[k], body[k]);
    end
    check_value({name, " busy_after"}, bus.busy, 0);
    check_value({name, " err_held"}, bus.err_code, exp_err);
  endtask

  initial begin
    byteq_t     body;
    logic [7:0] pb;
    logic [23:0] stream;
    int         nb;
    int         xb;
    int         c0;
    total   = 0;
    bad     = 0;
    cyc     = 0;
    done_n  = 0;
    reset_n = 1'b0;
    clear_inputs();
    #12;
    check_zero_outputs("in_reset");
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    check_zero_outputs("after_reset");

    // DATA0 with 8 payload bytes and 2 CRC bytes, good and bad CRC.
    body.delete();
    for (int i = 0; i < 10; i++) body.push_back(8'(i));
    run_pkt("data0_good", 8'hC3, body, 0, 1'b1, 0, 1'b0);
    run_pkt("data0_badcrc", 8'hC3, body, 0, 1'b0, 0, 1'b0);

    body.delete();
    run_pkt("pid_bad", 8'h33, body, 0, 1'b1, 0, 1'b0);
    run_pkt("ack_misalign", 8'hD2, body, 3, 1'b1, 0, 1'b0);
    run_pkt("ack_ok", 8'hD2, body, 0, 1'b0, 0, 1'b0);
    run_pkt("data1_empty_badcrc", 8'h4B, body, 0, 1'b0, 2, 1'b0);

    body.delete();
    for (int i = 0; i < MAX_B + 1; i++) body.push_back(8'($urandom));
    run_pkt("overflow", 8'h4B, body, 0, 1'b1, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      body.delete();
      case ($urandom_range(0, 7))
        0:       pb = 8'hC3;
        1:       pb = 8'h4B;
        2:       pb = 8'hD2;
        3:       pb = 8'h5A;
        4:       pb = 8'hE1;
        5:       pb = 8'h69;
        6:       pb = 8'h2D;
        default: pb = 8'($urandom);
      endcase
      nb = $urandom_range(0, 10);
      repeat (nb) body.push_back(8'($urandom));
      xb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_pkt($sformatf("rnd%0d", t), pb, body, xb, 1'($urandom_range(0, 1)), $urandom_range(0, 5), 1'b1);
    end

    // Reset in the middle of a DATA0 packet: state dropped, no pkt_done.
    wait_idle("midreset");
    rx_q.delete();
    done_n = 0;
    stream = {8'h34, 8'h12, 8'hC3};
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b1, stream[i], 1'b0, 1'b0);
    clear_inputs();
    check_value("midreset busy_before", bus.busy, 1);
    check_value("midreset count_before", bus.byte_count, 1);
    check_value("midreset pid_before", bus.pid, 3);
    reset_pulse("midreset");
    repeat (10) @(negedge clock);
    check_value("midreset no_done", done_n, 0);
    check_value("midreset busy_later", bus.busy, 0);

`ifdef RX_PACKET_CONTROLLER_TIMEOUT_EN
    wait_idle("timeout");
    done_n = 0;
    c0 = cyc;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    for (int w = 0; w < TMO + 20 && done_n == 0; w++) @(negedge clock);
    check_value("timeout done_cnt", done_n, 1);
    check_value("timeout err", done_err, 5);
    check_value("timeout latency", done_cyc, c0 + TMO + 1);
    body.delete();
    body.push_back(8'hA5);
    run_pkt("bit_at_timeout", 8'hD2, body, 0, 1'b0, TMO - 1, 1'b0);
`else
    wait_idle("no_timeout");
    done_n = 0;
    c0 = cyc;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    clear_inputs();
    repeat (TMO + 45) @(negedge clock);
    check_value("no_timeout busy", bus.busy, 1);
    check_value("no_timeout done_cnt", done_n, 0);
    check_value("no_timeout elapsed", (cyc - c0 > TMO) ? 1 : 0, 1);
    reset_pulse("no_timeout_reset");
    repeat (3) @(negedge clock);
    check_value("no_timeout reset_done", done_n, 0);
`endif

    body.delete();
    body.push_back(8'h5C);
    body.push_back(8'hE7);
    run_pkt("post_reset", 8'hC3, body, 0, 1'b1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
